// File: rtl/snn_lif_layer_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire spiking layer.
package snn_lif_layer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    localparam int RESET_ZERO = 0;
    localparam int RESET_SUB  = 1;

    // Clamp a signed 32-bit sum into a signed range of the given width (width <= 31).
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/snn_lif_layer_if.sv
// Timestep control and spike result bundle between a spike source and the LIF layer.
interface snn_lif_layer_if #(
    parameter int N_IN  = 25,
    parameter int N_OUT = 10
);
    logic             pulse;
    logic             mem_clear;
    logic [N_IN-1:0]  pixelsIn;
    logic [N_OUT-1:0] spk_out;
    logic             spk_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output pulse, mem_clear, pixelsIn,
        input  spk_out, spk_valid, busy, overrun
    );

    modport slave (
        input  pulse, mem_clear, pixelsIn,
        output spk_out, spk_valid, busy, overrun
    );
endinterface

// File: rtl/lif_neuron_update.sv
// One LIF neuron: exact weight accumulator, saturating membrane, refractory counter
// and the fire decision taken in the single FIRE cycle of each timestep.
module lif_neuron_update
    import snn_lif_layer_pkg::*;
#(
    parameter int N_IN       = 25,
    parameter int W_W        = 8,
    parameter int MEM_W      = 16,
    parameter int LEAK_SHIFT = 0,
    parameter int RESET_MODE = RESET_ZERO,
    parameter int REFRAC     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic                    pix_bit,
    input  logic signed [W_W-1:0]   weight,
    input  logic                    fire_en,
    input  logic signed [W_W-1:0]   bias,
    input  logic signed [MEM_W-1:0] threshold,
    output logic                    spk
);

    localparam int ACC_W = W_W + $clog2(N_IN) + 1;
    localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [MEM_W-1:0] v;
    logic signed [MEM_W-1:0] v_leak;
    logic signed [MEM_W-1:0] s;
    logic signed [31:0]      s_wide;
    logic [REF_W-1:0]        ref_cnt;

    assign w_ext = ACC_W'(weight);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (acc_en && pix_bit) begin
            acc <= acc + w_ext;
        end
    end

    // The three-term sum is formed at 32 bits so it can never wrap before clamping.
    always_comb begin
        v_leak = v;
        if (LEAK_SHIFT > 0) begin
            v_leak = v - (v >>> LEAK_SHIFT);
        end
        s_wide = sat(32'(v_leak) + 32'(acc) + 32'(bias), MEM_W);
        s      = s_wide[MEM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v       <= '0;
            ref_cnt <= '0;
            spk     <= 1'b0;
        end else if (clear) begin
            v       <= '0;
            ref_cnt <= '0;
        end else if (fire_en) begin
            if (ref_cnt != '0) begin
                v       <= '0;
                spk     <= 1'b0;
                ref_cnt <= ref_cnt - 1'b1;
            end else if (s >= threshold) begin
                spk     <= 1'b1;
                v       <= (RESET_MODE == RESET_SUB) ? s - threshold : '0;
                ref_cnt <= REF_W'(REFRAC);
            end else begin
                spk     <= 1'b0;
                v       <= s;
            end
        end
    end

endmodule

// File: rtl/snn_lif_layer.sv
// Layer of N_OUT leaky integrate-and-fire neurons fed by N_IN binary spikes; each accepted
// pulse runs N_IN accumulate cycles (one input per clock, all neurons in parallel) then one fire cycle.
module snn_lif_layer
    import snn_lif_layer_pkg::*;
#(
    parameter int N_IN       = 25,
    parameter int N_OUT      = 10,
    parameter int W_W        = 8,
    parameter int MEM_W      = 16,
    parameter int LEAK_SHIFT = 0,
    parameter int RESET_MODE = RESET_ZERO,
    parameter int REFRAC     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    snn_lif_layer_if.slave             bus,
    input  logic [N_IN*N_OUT*W_W-1:0]  weightsIn,
    input  logic [N_OUT*W_W-1:0]       biasIn,
    input  logic signed [MEM_W-1:0]    threshold
);

    localparam int              IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [N_IN-1:0]      pix;
    logic                 accept;
    logic                 clear;
    logic                 busy;
    logic                 acc_en;
    logic                 fire_en;
    logic                 pix_bit;
    logic                 spk_valid;
    logic                 overrun;
    logic [N_OUT*W_W-1:0] wrow;
    logic [N_OUT-1:0]     spk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.pulse) state_next = ST_ACCUM;
            ST_ACCUM: if (idx == IDX_LAST) state_next = ST_FIRE;
            ST_FIRE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        acc_en  = (state == ST_ACCUM);
        fire_en = (state == ST_FIRE);
    end

    // A clear coinciding with an accepted pulse zeroes membranes before the new timestep integrates.
    assign accept = (state == ST_IDLE) && bus.pulse;
    assign clear  = (state == ST_IDLE) && bus.mem_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            spk_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            spk_valid <= fire_en;
            if (busy && (bus.pulse || bus.mem_clear)) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                idx <= '0;
            end else if (acc_en) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix <= bus.pixelsIn;
        end
    end

    always_comb begin
        wrow    = '0;
        pix_bit = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(idx) == i) begin
                wrow    = weightsIn[i*N_OUT*W_W +: N_OUT*W_W];
                pix_bit = pix[i];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        lif_neuron_update #(
            .N_IN       (N_IN),
            .W_W        (W_W),
            .MEM_W      (MEM_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .RESET_MODE (RESET_MODE),
            .REFRAC     (REFRAC)
        ) u_neuron (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .start     (accept),
            .acc_en    (acc_en),
            .pix_bit   (pix_bit),
            .weight    (wrow[j*W_W +: W_W]),
            .fire_en   (fire_en),
            .bias      (biasIn[j*W_W +: W_W]),
            .threshold (threshold),
            .spk       (spk[j])
        );
    end

    assign bus.spk_out   = spk;
    assign bus.spk_valid = spk_valid;
    assign bus.busy      = busy;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_snn_lif_layer.sv
// Bench for snn_lif_layer: four instances (plain, subtract-reset, leak, refractory) share one
// stimulus stream and are checked every cycle against a timestep-level behavioural model.
module tb_snn_lif_layer;

    localparam int N_IN  = 25;
    localparam int N_OUT = 10;
    localparam int W_W   = 8;
    localparam int MEM_W = 16;
    localparam int NDUT  = 4;
    localparam int LK [NDUT] = '{0, 0, 1, 0};
    localparam int RM [NDUT] = '{0, 1, 0, 0};
    localparam int RF [NDUT] = '{0, 0, 0, 2};

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      pulse;
    logic                      mem_clear;
    logic [N_IN-1:0]           pixels;
    logic [N_IN*N_OUT*W_W-1:0] weights;
    logic [N_OUT*W_W-1:0]      biases;
    logic [MEM_W-1:0]          threshold;
    logic [N_OUT-1:0]          spk_a  [NDUT];
    logic                      vld_a  [NDUT];
    logic                      busy_a [NDUT];
    logic                      ovr_a  [NDUT];

    int wt [N_IN][N_OUT];
    int bs [N_OUT];
    int thr;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        weights = '0;
        biases  = '0;
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_OUT; j++)
                weights[(i*N_OUT+j)*W_W +: W_W] = W_W'(wt[i][j]);
        for (int j = 0; j < N_OUT; j++)
            biases[j*W_W +: W_W] = W_W'(bs[j]);
    end
    assign threshold = MEM_W'(thr);

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        snn_lif_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();
        assign bus.pulse     = pulse;
        assign bus.mem_clear = mem_clear;
        assign bus.pixelsIn  = pixels;
        snn_lif_layer #(
            .N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .MEM_W(MEM_W),
            .LEAK_SHIFT(LK[g]), .RESET_MODE(RM[g]), .REFRAC(RF[g])
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .bus       (bus),
            .weightsIn (weights),
            .biasIn    (biases),
            .threshold (threshold)
        );
        assign spk_a[g]  = bus.spk_out;
        assign vld_a[g]  = bus.spk_valid;
        assign busy_a[g] = bus.busy;
        assign ovr_a[g]  = bus.overrun;
    end

    // Behavioural model: membrane values as plain integers, one whole timestep evaluated at acceptance.
    int               mv   [NDUT][N_OUT];
    int               mref [NDUT][N_OUT];
    logic [N_OUT-1:0] m_pend [NDUT];
    logic [N_OUT-1:0] m_spk  [NDUT];
    int               cyc        = 0;
    int               busy_start = -100;
    int               busy_end   = -100;
    int               valid_cyc  = -100;
    logic             m_ovr      = 1'b0;
    bit               armed      = 1'b0;

    function automatic int clamp_mem(input int x);
        int hi;
        int lo;
        hi = (1 << (MEM_W - 1)) - 1;
        lo = -(1 << (MEM_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int floor_div(input int a, input int d);
        if (a < 0 && (a % d) != 0) return a / d - 1;
        return a / d;
    endfunction

    task automatic model_timestep();
        for (int k = 0; k < NDUT; k++) begin
            for (int j = 0; j < N_OUT; j++) begin
                int acc;
                int vl;
                int s;
                acc = 0;
                for (int i = 0; i < N_IN; i++)
                    if (pixels[i]) acc += wt[i][j];
                vl = mv[k][j];
                if (LK[k] > 0) vl = vl - floor_div(vl, 1 << LK[k]);
                s = clamp_mem(vl + acc + bs[j]);
                if (mref[k][j] > 0) begin
                    mv[k][j]     = 0;
                    m_pend[k][j] = 1'b0;
                    mref[k][j]   = mref[k][j] - 1;
                end else if (s >= thr) begin
                    m_pend[k][j] = 1'b1;
                    mv[k][j]     = (RM[k] != 0) ? s - thr : 0;
                    mref[k][j]   = RF[k];
                end else begin
                    m_pend[k][j] = 1'b0;
                    mv[k][j]     = s;
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NDUT; k++)
            for (int j = 0; j < N_OUT; j++) begin
                mv[k][j]   = 0;
                mref[k][j] = 0;
            end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                model_clear();
                for (int k = 0; k < NDUT; k++) m_spk[k] = '0;
                busy_start = -100;
                busy_end   = -100;
                valid_cyc  = -100;
                m_ovr      = 1'b0;
                armed      = 1'b1;
            end else begin
                bit m_busy;
                m_busy = (cyc >= busy_start) && (cyc <= busy_end);
                if (m_busy && (pulse || mem_clear)) m_ovr = 1'b1;
                if (!m_busy && mem_clear) model_clear();
                if (!m_busy && pulse) begin
                    model_timestep();
                    busy_start = cyc + 1;
                    busy_end   = cyc + N_IN + 1;
                    valid_cyc  = cyc + N_IN + 2;
                end
            end
            cyc++;
            if (cyc == valid_cyc)
                for (int k = 0; k < NDUT; k++) m_spk[k] = m_pend[k];
        end
    end

    task automatic cmp(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d got=%0h expected=%0h", name, k, cyc, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int k = 0; k < NDUT; k++) begin
                    cmp("spk_out",   k, 32'(spk_a[k]), 32'(m_spk[k]));
                    cmp("spk_valid", k, 32'(vld_a[k]), 32'(cyc == valid_cyc));
                    cmp("busy",      k, 32'(busy_a[k]), 32'((cyc >= busy_start) && (cyc <= busy_end)));
                    cmp("overrun",   k, 32'(ovr_a[k]), 32'(m_ovr));
                end
            end
        end
    end

    task automatic set_w(input int val);
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_OUT; j++) wt[i][j] = val;
    endtask

    task automatic set_row0(input int val);
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_OUT; j++) wt[i][j] = (i == 0) ? val : 0;
    endtask

    task automatic set_b(input int val);
        for (int j = 0; j < N_OUT; j++) bs[j] = val;
    endtask

    // Pulse in the current cycle T; returns #1 into cycle T+N_IN+2, the spk_valid cycle.
    task automatic step(input logic [N_IN-1:0] p);
        pixels = p;
        pulse  = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
        repeat (N_IN + 1) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_clear = 1'b1;
        @(posedge clk);
        #1 mem_clear = 1'b0;
    endtask

    initial begin
        int nv;
        reset = 1'b1; pulse = 1'b1; mem_clear = 1'b0; pixels = '1;
        thr = 40; set_w(2); set_b(0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; pulse = 1'b0;
        cmp("rst_spk_out",   0, 32'(spk_a[0]), 32'd0);
        cmp("rst_spk_valid", 0, 32'(vld_a[0]), 32'd0);
        cmp("rst_busy",      0, 32'(busy_a[0]), 32'd0);
        cmp("rst_overrun",   0, 32'(ovr_a[0]), 32'd0);

        // all inputs fire with weight 2: s = 50 >= 40 on every neuron
        step('1);
        cmp("t2_valid_at_T27", 0, 32'(vld_a[0]), 32'd1);
        cmp("t2_spk_out",      0, 32'(spk_a[0]), 32'h3FF);

        clear_mem();
        thr = 30;
        step('1);
        cmp("t3_first_spk", 1, 32'(spk_a[1]), 32'h3FF);
        set_b(10);
        step('0);
        cmp("t3_residual_spk", 1, 32'(spk_a[1]), 32'h3FF);

        // leak by half: 20, 30, 35, then 18+20 = 38 reaches the probe threshold
        set_b(0);
        clear_mem();
        set_row0(20);
        thr = 100;
        for (int n = 0; n < 3; n++) begin
            step(N_IN'(1));
            cmp("t4_leak_spk", 2, 32'(spk_a[2]), 32'd0);
        end
        thr = 38;
        step(N_IN'(1));
        cmp("t4_leak_probe", 2, 32'(spk_a[2]), 32'h3FF);

        clear_mem();
        set_w(-128); set_b(-128); thr = 40;
        for (int n = 0; n < 12; n++) step('1);
        cmp("t5_neg_sat_spk", 0, 32'(spk_a[0]), 32'd0);
        clear_mem();
        set_w(2); set_b(0); thr = 50;
        step('1);
        cmp("t5_clear_probe", 0, 32'(spk_a[0]), 32'h3FF);

        // +3302 per timestep: 29718 after nine, clamps to 32767 on the tenth
        clear_mem();
        set_w(127); set_b(127); thr = 32767;
        for (int n = 1; n <= 10; n++) begin
            step('1);
            if (n == 9) cmp("sat_pos_below", 0, 32'(spk_a[0]), 32'd0);
        end
        cmp("sat_pos_spk", 0, 32'(spk_a[0]), 32'h3FF);

        clear_mem();
        set_w(2); set_b(0); thr = 40;
        pixels = '1;
        pulse  = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
        repeat (4) @(posedge clk);
        #1 pulse = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
        repeat (N_IN - 4) @(posedge clk);
        #1;
        cmp("t6_spk1",    3, 32'(spk_a[3]), 32'h3FF);
        cmp("t6_overrun", 3, 32'(ovr_a[3]), 32'd1);
        step('1);
        cmp("t6_spk2", 3, 32'(spk_a[3]), 32'd0);
        step('1);
        cmp("t6_spk3", 3, 32'(spk_a[3]), 32'd0);
        step('1);
        cmp("t6_spk4", 3, 32'(spk_a[3]), 32'h3FF);

        pulse = 1'b1;
        @(posedge clk);
        #1 pulse = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cmp("t6_busy_after_reset", 3, 32'(busy_a[3]), 32'd0);
        cmp("t6_overrun_cleared",  3, 32'(ovr_a[3]), 32'd0);
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (vld_a[3]) nv++;
        end
        cmp("t6_no_valid_after_abort", 3, 32'(nv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
